// File: rtl/led_pkg.sv
// ------------------------------------------------------------------
// led_pkg : shared widths, channel positions and FSM encoding for the LED path
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam int COLOR_W = 24;

  localparam int RGB_R_LSB = 16;
  localparam int RGB_G_LSB = 8;
  localparam int RGB_B_LSB = 0;

  localparam int GRB_G_LSB = 16;
  localparam int GRB_R_LSB = 8;
  localparam int GRB_B_LSB = 0;

  // 51.2 us latch gap at 50 MHz
  localparam int DEFAULT_RESET_CYCLES = 2560;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  function automatic logic [COLOR_W-1:0] pack_grb(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pixel_scaler.sv
// ------------------------------------------------------------------
// led_pixel_scaler : per-channel (ch * (bright+1)) >> 8, RGB in, GRB out
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module led_pixel_scaler
  import led_pkg::*;
(
  input  logic [COLOR_W-1:0] i_rgb,
  input  logic [7:0]         i_bright,
  output logic [COLOR_W-1:0] o_grb
);

  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [8:0] mult);
    logic [15:0] prod;
    prod = 16'(ch) * 16'(mult);
    return 8'(prod >> 8);
  endfunction

  logic [8:0] w_mult;
  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;

  // bright+1 makes 255 an exact identity and keeps the product within 16 bits
  assign w_mult = {1'b0, i_bright} + 9'd1;
  assign w_r    = scale_ch(i_rgb[RGB_R_LSB +: 8], w_mult);
  assign w_g    = scale_ch(i_rgb[RGB_G_LSB +: 8], w_mult);
  assign w_b    = scale_ch(i_rgb[RGB_B_LSB +: 8], w_mult);
  assign o_grb  = pack_grb(w_r, w_g, w_b);

endmodule

`default_nettype wire

// File: rtl/led_frame_sequencer.sv
// ------------------------------------------------------------------
// led_frame_sequencer : streams scaled GRB pixels per frame, then holds the latch gap
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [COLOR_W-1:0] i_wr_color,
  input  logic [7:0]         i_brightness,
  input  logic               i_frame_start,
  output logic               o_busy,
  output logic [COLOR_W-1:0] o_pixel_color,
  output logic               o_pixel_valid,
  input  logic               i_pixel_ready,
  output logic               o_frame_done
);

  localparam int c_IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int c_LCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [ADDR_W:0]    c_NUM_LEDS = (ADDR_W+1)'(NUM_LEDS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_LEDS - 1);
  localparam logic [c_LCNT_W-1:0] c_LCNT_MAX = c_LCNT_W'(RESET_CYCLES - 1);

  state_t              r_state;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_LCNT_W-1:0] r_lcnt;
  logic [7:0]          r_bright;
  logic [COLOR_W-1:0]  r_mem [0:NUM_LEDS-1];
  logic [COLOR_W-1:0]  r_rd_data;

  logic                w_wr_ok;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [COLOR_W-1:0]  w_scaled;

  assign w_wr_ok  = i_wr_en && ({1'b0, i_wr_addr} < c_NUM_LEDS);
  assign w_wr_idx = i_wr_addr[c_IDX_W-1:0];

  // Read-first: a same-edge write to the fetched address lands after the read
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_wr_idx] <= i_wr_color;
    if (r_state == ST_FETCH) r_rd_data <= r_mem[r_idx];
  end

  led_pixel_scaler u_scaler (
    .i_rgb    (r_rd_data),
    .i_bright (r_bright),
    .o_grb    (w_scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_lcnt        <= '0;
      r_bright      <= '0;
      o_busy        <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_pixel_color <= '0;
      o_frame_done  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_frame_start) begin
            r_bright <= i_brightness;
            r_idx    <= '0;
            o_busy   <= 1'b1;
            r_state  <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_SEND;
        ST_SEND: begin
          // First SEND cycle loads the word; it then holds until accepted
          if (!o_pixel_valid) begin
            o_pixel_color <= w_scaled;
            o_pixel_valid <= 1'b1;
          end else if (i_pixel_ready) begin
            o_pixel_valid <= 1'b0;
            if (r_idx == c_LAST_IDX) begin
              r_lcnt  <= '0;
              r_state <= ST_LATCH;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_LATCH: begin
          if (r_lcnt == c_LCNT_MAX) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_lcnt <= r_lcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_frame_sequencer.sv
// ------------------------------------------------------------------
// tb_led_frame_sequencer : scoreboard bench with a behavioural pixel/frame model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_led_frame_sequencer;

  localparam int NUM_LEDS = 8;
  localparam int ADDR_W   = 4;
  localparam int RC       = 50;
  localparam int BUDGET   = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [3:0]  i_wr_addr = '0;
  logic [23:0] i_wr_color = '0;
  logic [7:0]  i_brightness = '0;
  logic        i_frame_start = 1'b0;
  logic        i_pixel_ready = 1'b0;
  logic        o_busy;
  logic [23:0] o_pixel_color;
  logic        o_pixel_valid;
  logic        o_frame_done;

  always #5 clk = ~clk;

  led_frame_sequencer #(
    .NUM_LEDS     (NUM_LEDS),
    .ADDR_W       (ADDR_W),
    .RESET_CYCLES (RC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_color    (i_wr_color),
    .i_brightness  (i_brightness),
    .i_frame_start (i_frame_start),
    .o_busy        (o_busy),
    .o_pixel_color (o_pixel_color),
    .o_pixel_valid (o_pixel_valid),
    .i_pixel_ready (i_pixel_ready),
    .o_frame_done  (o_frame_done)
  );

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          pending = 0;
  int          done_cnt = 0;
  int          pix_in_frame = 0;
  int          last_hs = 0;
  int          done_edge = -1;
  int          ready_mode = 0;
  int          hold_cnt = 0;
  bit          gap_chk = 1'b0;
  logic [23:0] model_mem [NUM_LEDS];
  logic [24:0] exp_q [$];
  logic [24:0] mon_e;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [23:0] pc = '0;

  always @(posedge clk) cyc++;

  // Reference: each channel times (brightness+1), divided by 256, emitted G,R,B
  function automatic logic [23:0] ref_px(input logic [23:0] rgb, input int b);
    int r, g, bl;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    bl = int'(rgb[7:0]);
    return {8'((g * (b + 1)) / 256), 8'((r * (b + 1)) / 256), 8'((bl * (b + 1)) / 256)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int addr, input logic [23:0] c);
    i_wr_en    = 1'b1;
    i_wr_addr  = 4'(addr);
    i_wr_color = c;
    tick();
    i_wr_en = 1'b0;
    if (addr < NUM_LEDS) model_mem[addr] = c;
  endtask

  task automatic start_frame(input int b);
    for (int i = 0; i < NUM_LEDS; i++)
      exp_q.push_back({(i == NUM_LEDS - 1), ref_px(model_mem[i], b)});
    pending++;
    i_brightness  = 8'(b);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    last_hs  = cyc;
    hold_cnt = 0;
    check("busy_after_start", 32'(o_busy), 1);
  endtask

  task automatic wait_frame(input bit stray);
    int s;
    int i;
    s = done_cnt;
    i = 0;
    while (done_cnt == s && i < BUDGET) begin
      tick();
      i++;
      i_frame_start = stray && o_busy && ($urandom_range(0, 3) == 0);
      if (stray) i_brightness = 8'($urandom);
    end
    i_frame_start = 1'b0;
    if (done_cnt == s) begin
      checks++;
      $display("FAIL frame_timeout: got no frame_done within %0d cycles", BUDGET);
    end
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = stall pixel 3 for 100 cycles
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: i_pixel_ready = 1'b1;
      1: i_pixel_ready = 1'($urandom_range(0, 1));
      default: begin
        if (o_pixel_valid && pix_in_frame == 3 && hold_cnt < 100) begin
          i_pixel_ready = 1'b0;
          hold_cnt++;
        end else begin
          i_pixel_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: a handshake seen here completes on the next rising edge (cyc+1)
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", 32'(o_pixel_valid), 1);
        check("hold_color", 32'(o_pixel_color), 32'(pc));
      end
      if (pv && pr) check("valid_drop", 32'(o_pixel_valid), 0);
      if (o_pixel_valid && i_pixel_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL extra_pixel: got %h required no pixel", o_pixel_color);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel_color", 32'(o_pixel_color), 32'(mon_e[23:0]));
          if (gap_chk) check("hs_spacing", 32'(cyc + 1 - last_hs), 3);
          last_hs = cyc + 1;
          pix_in_frame++;
          if (mon_e[24]) begin
            done_edge    = cyc + 1 + RC;
            pix_in_frame = 0;
          end
        end
      end
      if (o_frame_done) begin
        check("done_pending", 32'(pending > 0), 1);
        check("done_time", 32'(cyc), 32'(done_edge));
        check("busy_at_done", 32'(o_busy), 0);
        if (pending > 0) pending--;
        done_cnt++;
      end
      pv = o_pixel_valid;
      pr = i_pixel_ready;
      pc = o_pixel_color;
    end
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", 32'(o_busy), 0);
    check("rst_valid", 32'(o_pixel_valid), 0);
    check("rst_color", 32'(o_pixel_color), 0);
    check("rst_done", 32'(o_frame_done), 0);

    ready_mode = 0;
    for (int i = 0; i < NUM_LEDS; i++) write_px(i, 24'($urandom));

    // Scaling corners on a known pixel
    write_px(0, 24'hFF8040);
    gap_chk = 1'b1;
    start_frame(255); wait_frame(1'b0);
    start_frame(127); wait_frame(1'b0);
    start_frame(0);   wait_frame(1'b0);

    // Same-edge write to idx 5 as its read: old value now, new value next frame
    write_px(5, 24'h123456);
    start_frame(255);
    repeat (15) tick();
    i_wr_en    = 1'b1;
    i_wr_addr  = 4'd5;
    i_wr_color = 24'hABCDEF;
    tick();
    i_wr_en = 1'b0;
    model_mem[5] = 24'hABCDEF;
    wait_frame(1'b0);
    write_px(9, 24'h00FF00);
    write_px(15, 24'h0000FF);
    start_frame(255); wait_frame(1'b0);

    // Backpressure on pixel 3
    gap_chk = 1'b0;
    ready_mode = 2;
    start_frame(200); wait_frame(1'b0);

    // Stray requests during SEND/LATCH, then a quiet window
    ready_mode = 0;
    gap_chk = 1'b1;
    start_frame(90); wait_frame(1'b1);
    repeat (RC + 20) tick();
    check("no_extra_frames", 32'(pending), 0);

    // Randomised frames with random ready and idle-time writes
    gap_chk = 1'b0;
    ready_mode = 1;
    repeat (10) begin
      repeat ($urandom_range(1, 4)) write_px($urandom_range(0, 15), 24'($urandom));
      start_frame($urandom_range(0, 255));
      wait_frame(1'b1);
    end

    // Reset while pixel 3 is stalled with valid high
    ready_mode = 2;
    start_frame(255);
    for (int i = 0; i < BUDGET && !(pix_in_frame == 3 && hold_cnt >= 10); i++) tick();
    check("stall_reached", 32'(o_pixel_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(o_busy), 0);
    check("arst_valid", 32'(o_pixel_valid), 0);
    check("arst_color", 32'(o_pixel_color), 0);
    check("arst_done", 32'(o_frame_done), 0);
    exp_q.delete();
    pending = 0;
    pix_in_frame = 0;
    ready_mode = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", 32'(o_busy), 0);
    check("post_rst_valid", 32'(o_pixel_valid), 0);
    check("post_rst_color", 32'(o_pixel_color), 0);
    check("post_rst_done", 32'(o_frame_done), 0);
    gap_chk = 1'b1;
    start_frame(255); wait_frame(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
